life_controller: RTL

LIFE_CONTROLLER -- requirements
Module: life_controller

---
 rtl/life_controller.sv | 124 ++++++++++++
 1 files changed

// File: rtl/life_controller.sv
// Life grid sequencer: turns step/run/clear key pulses into
// gen/clear strobes for the grid and tracks the generation count.
module life_controller #(
   parameter int unsigned TICK_DIV = 50
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        step_p,
   input  logic        run_p,
   input  logic        clear_p,
   input  logic        grid_done,
   output logic        gen_start,
   output logic        clear_start,
   output logic        running,
   output logic        busy,
   output logic [15:0] gen_count
);

   typedef enum logic [1:0] {
      PAUSE,
      RUN,
      WAIT_GEN,
      WAIT_CLR
   } state_t;

   localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

   state_t      state_q;
   logic        run_mode_q;
   logic        clear_pend_q;
   logic        gen_start_q;
   logic        clear_start_q;
   logic [15:0] tick_q;
   logic [15:0] gen_count_q;

   // Commands seen while a generation is in flight are folded in first,
   // so an exit on the same edge already reflects them.
   logic        wg_run_mode;
   logic        wg_clear_pend;

   assign wg_run_mode   = run_mode_q ^ run_p;
   assign wg_clear_pend = clear_pend_q | clear_p;

   // Controller state, counters and registered strobes
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= PAUSE;
         run_mode_q    <= 1'b0;
         clear_pend_q  <= 1'b0;
         gen_start_q   <= 1'b0;
         clear_start_q <= 1'b0;
         tick_q        <= 16'd0;
         gen_count_q   <= 16'd0;
      end else begin
         gen_start_q   <= 1'b0;
         clear_start_q <= 1'b0;
         unique case (state_q)
            PAUSE: begin
               if (clear_p) begin
                  clear_start_q <= 1'b1;
                  state_q       <= WAIT_CLR;
               end else if (step_p) begin
                  gen_start_q <= 1'b1;
                  run_mode_q  <= 1'b0;
                  state_q     <= WAIT_GEN;
               end else if (run_p) begin
                  run_mode_q <= 1'b1;
                  tick_q     <= 16'd0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               if (clear_p) begin
                  clear_start_q <= 1'b1;
                  tick_q        <= 16'd0;
                  state_q       <= WAIT_CLR;
               end else if (run_p) begin
                  run_mode_q <= 1'b0;
                  tick_q     <= 16'd0;
                  state_q    <= PAUSE;
               end else if (tick_q == TICK_LAST) begin
                  gen_start_q <= 1'b1;
                  tick_q      <= 16'd0;
                  state_q     <= WAIT_GEN;
               end else begin
                  tick_q <= tick_q + 16'd1;
               end
            end
            WAIT_GEN: begin
               run_mode_q   <= wg_run_mode;
               clear_pend_q <= wg_clear_pend;
               if (grid_done) begin
                  gen_count_q <= gen_count_q + 16'd1;
                  if (wg_clear_pend) begin
                     clear_start_q <= 1'b1;
                     clear_pend_q  <= 1'b0;
                     state_q       <= WAIT_CLR;
                  end else if (wg_run_mode) begin
                     tick_q  <= 16'd0;
                     state_q <= RUN;
                  end else begin
                     state_q <= PAUSE;
                  end
               end
            end
            WAIT_CLR: begin
               if (grid_done) begin
                  gen_count_q <= 16'd0;
                  run_mode_q  <= 1'b0;
                  state_q     <= PAUSE;
               end
            end
            default: state_q <= PAUSE;
         endcase
      end
   end

   assign gen_start   = gen_start_q;
   assign clear_start = clear_start_q;
   assign running     = run_mode_q;
   assign busy        = (state_q == WAIT_GEN) || (state_q == WAIT_CLR);
   assign gen_count   = gen_count_q;

endmodule
